// File: rtl/f_pc_unit_if.sv
// Instruction-memory fetch bus between the fetch PC unit and instruction memory.
//
// Signals:
//   i_inst_addr   32  fetch address driven by the PC unit (word address in bytes)
//   i_inst_rdata  32  instruction word returned by instruction memory
//
// Modports:
//   master  PC unit side: drives the address, receives the read data
//   slave   memory side: receives the address, drives the read data
interface f_pc_unit_if;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;

    modport master (
        output i_inst_addr,
        input  i_inst_rdata
    );

    modport slave (
        input  i_inst_addr,
        output i_inst_rdata
    );
endinterface

// File: rtl/f_pc_unit.sv
// Fetch-stage program-counter unit of the P7 MIPS pipeline.
// Holds the fetch PC, chooses the next PC, drives the instruction-memory
// address, flags fetch address errors (AdEL) and marks delay-slot
// instructions. Everything except the PC register is combinational, so the
// F/D register can latch PC_F/Instr_F/F_ExcCode/BDIn_F at the same edge that
// the PC moves on.
//
// Ports:
//   clk          in   1   system clock, rising-edge active
//   reset        in   1   asynchronous active-low reset (0 = in reset)
//   enable_F     in   1   1 = PC may advance, 0 = stall
//   Req          in   1   exception/interrupt request from CP0
//   eret_D       in   1   eret instruction in D
//   EPC          in   32  return address from CP0
//   br_taken_D   in   1   branch/jump in D resolved taken
//   br_target_D  in   32  target of that branch/jump
//   is_jump_D    in   1   instruction in D is a branch/jump (taken or not)
//   imem         if       instruction-memory bus (master side)
//   PC_F         out  32  current fetch PC
//   Instr_F      out  32  fetched instruction after squashing
//   F_ExcCode    out  5   0 = none, 4 = AdEL
//   BDIn_F       out  1   instruction in F sits in a branch delay slot
module f_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI    = 32'h0000_6FFC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_F,
    input  logic              Req,
    input  logic              eret_D,
    input  logic [31:0]       EPC,
    input  logic              br_taken_D,
    input  logic [31:0]       br_target_D,
    input  logic              is_jump_D,
    f_pc_unit_if.master       imem,
    output logic [31:0]       PC_F,
    output logic [31:0]       Instr_F,
    output logic [4:0]        F_ExcCode,
    output logic              BDIn_F
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        adel;

    // Next-PC selection. A CP0 request must win even during a stall, so it
    // is checked before enable_F. Redirect targets are not masked; a bad
    // target simply shows up as AdEL once it becomes the PC.
    always_comb begin
        pc_next = pc + 32'd4;
        if (Req) begin
            pc_next = HANDLER_PC;
        end else if (!enable_F) begin
            pc_next = pc;
        end else if (eret_D) begin
            pc_next = EPC;
        end else if (br_taken_D) begin
            pc_next = br_target_D;
        end
    end

    // The PC is the only state in this unit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // Misaligned or outside the text segment (unsigned compare).
    assign adel = (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);

    // eret has no delay slot, so the sequential fetch behind it is squashed
    // to a nop; that squash also hides any AdEL on the discarded fetch.
    always_comb begin
        Instr_F   = imem.i_inst_rdata;
        F_ExcCode = EXC_NONE;
        if (eret_D) begin
            Instr_F   = 32'd0;
            F_ExcCode = EXC_NONE;
        end else if (adel) begin
            Instr_F   = 32'd0;
            F_ExcCode = EXC_ADEL;
        end
    end

    assign PC_F             = pc;
    assign imem.i_inst_addr = pc;
    assign BDIn_F           = is_jump_D;

endmodule

// File: tb/tb_f_pc_unit.sv
// Self-checking bench for f_pc_unit: directed scenarios followed by random
// stimulus, all checked against a behavioural model of the fetch PC.
module tb_f_pc_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI    = 32'h0000_6FFC;

    logic        clk;
    logic        reset;
    logic        enable_F;
    logic        Req;
    logic        eret_D;
    logic [31:0] EPC;
    logic        br_taken_D;
    logic [31:0] br_target_D;
    logic        is_jump_D;
    logic [31:0] PC_F;
    logic [31:0] Instr_F;
    logic [4:0]  F_ExcCode;
    logic        BDIn_F;

    f_pc_unit_if imem ();

    f_pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .enable_F    (enable_F),
        .Req         (Req),
        .eret_D      (eret_D),
        .EPC         (EPC),
        .br_taken_D  (br_taken_D),
        .br_target_D (br_target_D),
        .is_jump_D   (is_jump_D),
        .imem        (imem.master),
        .PC_F        (PC_F),
        .Instr_F     (Instr_F),
        .F_ExcCode   (F_ExcCode),
        .BDIn_F      (BDIn_F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [31:0] model_pc;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Address-error rule in plain arithmetic terms.
    function automatic bit model_adel(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < TEXT_LO) || (pc > TEXT_HI);
    endfunction

    // Check the combinational F outputs against the model for the current PC.
    task automatic check_f_outputs(input string tag);
        logic [31:0] exp_instr;
        logic [31:0] exp_exc;
        if (eret_D) begin
            exp_instr = 32'd0;
            exp_exc   = 32'd0;
        end else if (model_adel(model_pc)) begin
            exp_instr = 32'd0;
            exp_exc   = 32'd4;
        end else begin
            exp_instr = imem.i_inst_rdata;
            exp_exc   = 32'd0;
        end
        check_output({tag, ".pc"},    PC_F, model_pc);
        check_output({tag, ".addr"},  imem.i_inst_addr, model_pc);
        check_output({tag, ".instr"}, Instr_F, exp_instr);
        check_output({tag, ".exc"},   {27'd0, F_ExcCode}, exp_exc);
        check_output({tag, ".bd"},    {31'd0, BDIn_F}, {31'd0, is_jump_D});
    endtask

    // Drive one cycle of inputs, check F outputs, clock, then check the new PC.
    task automatic apply_stimulus(input string tag, input bit en, input bit req,
                                  input bit eret, input logic [31:0] epc,
                                  input bit br, input logic [31:0] tgt, input bit jmp);
        logic [31:0] next_pc;
        enable_F          = en;
        Req               = req;
        eret_D            = eret;
        EPC               = epc;
        br_taken_D        = br;
        br_target_D       = tgt;
        is_jump_D         = jmp;
        imem.i_inst_rdata = $urandom;
        #2;
        check_f_outputs(tag);
        if (!reset)       next_pc = RESET_PC;
        else if (req)     next_pc = HANDLER_PC;
        else if (!en)     next_pc = model_pc;
        else if (eret)    next_pc = epc;
        else if (br)      next_pc = tgt;
        else              next_pc = model_pc + 32'd4;
        @(posedge clk);
        #1;
        model_pc = next_pc;
        check_output({tag, ".next"}, PC_F, model_pc);
    endtask

    task automatic seq(input string tag);
        apply_stimulus(tag, 1, 0, 0, 32'd0, 0, 32'd0, 0);
    endtask

    function automatic logic [31:0] random_target();
        case ($urandom_range(0, 3))
            0: return TEXT_LO + ($urandom_range(0, 16'h0FFF) << 2);
            1: return TEXT_LO + $urandom_range(0, 16'h3FFF);
            2: return $urandom;
            default: return TEXT_HI - ($urandom_range(0, 3) << 2);
        endcase
    endfunction

    initial begin
        reset             = 1'b0;
        enable_F          = 1'b1;
        Req               = 1'b0;
        eret_D            = 1'b0;
        EPC               = 32'd0;
        br_taken_D        = 1'b0;
        br_target_D       = 32'd0;
        is_jump_D         = 1'b0;
        imem.i_inst_rdata = 32'h1234_5678;
        model_pc          = RESET_PC;

        // Reset held for three cycles, then sequential fetch.
        repeat (3) @(posedge clk);
        #1;
        check_f_outputs("reset");
        reset = 1'b1;
        seq("seq0");
        seq("seq1");
        seq("seq2");
        seq("seq3");

        // Taken branch at 0x3010 into 0x3100.
        check_output("at3010", PC_F, 32'h0000_3010);
        apply_stimulus("branch", 1, 0, 0, 32'd0, 1, 32'h0000_3100, 1);
        check_output("br_tgt", PC_F, 32'h0000_3100);

        // Stall at 0x3020 with a pending taken branch.
        apply_stimulus("to3020", 1, 0, 0, 32'd0, 1, 32'h0000_3020, 1);
        apply_stimulus("stall0", 0, 0, 0, 32'd0, 1, 32'h0000_3400, 1);
        apply_stimulus("stall1", 0, 0, 0, 32'd0, 1, 32'h0000_3400, 1);
        check_output("held", PC_F, 32'h0000_3020);
        apply_stimulus("release", 1, 0, 0, 32'd0, 1, 32'h0000_3400, 1);

        // Req beats stall and eret.
        apply_stimulus("req", 0, 1, 1, 32'h0000_3204, 0, 32'd0, 0);
        check_output("handler", PC_F, 32'h0000_4180);

        // Walk to 0x4190, then eret squash.
        repeat (4) seq("walk");
        apply_stimulus("eret", 1, 0, 1, 32'h0000_3204, 0, 32'd0, 0);
        check_output("epc", PC_F, 32'h0000_3204);

        // eret together with a taken branch: EPC wins.
        apply_stimulus("eret_br", 1, 0, 1, 32'h0000_3300, 1, 32'h0000_3500, 1);

        // AdEL on a misaligned target and on an out-of-range target.
        apply_stimulus("to3002", 1, 0, 0, 32'd0, 1, 32'h0000_3002, 1);
        seq("adel_mis");
        check_output("pc3006", PC_F, 32'h0000_3006);
        apply_stimulus("to7000", 1, 0, 0, 32'd0, 1, 32'h0000_7000, 1);
        seq("adel_hi");
        check_output("pc7004", PC_F, 32'h0000_7004);

        // eret squash hides AdEL on the discarded fetch.
        apply_stimulus("eret_adel", 1, 0, 1, 32'h0000_3008, 0, 32'd0, 0);

        // PC wraps at the top of the address space.
        apply_stimulus("toTop", 1, 0, 0, 32'd0, 1, 32'hFFFF_FFFC, 1);
        seq("wrap");
        check_output("pc0", PC_F, 32'h0000_0000);

        // Asynchronous reset mid-stall with a redirect pending.
        apply_stimulus("pre_rst", 0, 0, 0, 32'd0, 1, 32'h0000_3800, 1);
        reset    = 1'b0;
        model_pc = RESET_PC;
        #1;
        check_output("async_rst", PC_F, RESET_PC);
        apply_stimulus("in_rst", 1, 1, 0, 32'd0, 1, 32'h0000_3800, 1);
        reset = 1'b1;
        seq("post_rst");
        check_output("pc3004", PC_F, 32'h0000_3004);

        // Random phase.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus("rand",
                           ($urandom_range(0, 3) != 0),
                           ($urandom_range(0, 19) == 0),
                           ($urandom_range(0, 9) == 0),
                           random_target(),
                           ($urandom_range(0, 3) == 0),
                           random_target(),
                           $urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/f_pc_unit.md
# f_pc_unit

Fetch-stage program-counter unit of the P7 MIPS pipeline. It sits directly upstream of the F/D pipeline register. It holds the fetch PC, selects the next PC, and drives the instruction-memory address. It also flags fetch address errors (AdEL) and marks delay-slot instructions, producing the PC_F, Instr_F, F_ExcCode and BDIn_F values that the F/D register latches.

## Interface
- RESET_PC, 32'h0000_3000, PC value on reset
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address
- TEXT_LO, 32'h0000_3000, lowest legal fetch address (inclusive)
- TEXT_HI, 32'h0000_6FFC, highest legal fetch address (inclusive)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- enable_F  in  1  1 = PC may advance; 0 = stall (hold PC)
- Req  in  1  exception/interrupt request from CP0
- eret_D  in  1  eret instruction currently in D
- EPC  in  32  return address from CP0
- br_taken_D  in  1  branch/jump in D resolved taken
- br_target_D  in  32  target of that branch/jump
- is_jump_D  in  1  instruction in D is any branch/jump, taken or not
- i_inst_rdata  in  32  instruction word read from instruction memory
- i_inst_addr  out  32  instruction-memory address (= PC_F)
- PC_F  out  32  current fetch PC
- Instr_F  out  32  fetched instruction after squashing
- F_ExcCode  out  5  0 = none, 5'd4 = AdEL
- BDIn_F  out  1  instruction in F is in a branch delay slot

## Operation
- Single state register: PC (32 bit). All outputs are combinational from PC and the current inputs.
- AdEL condition: PC[1:0] != 0, or PC < TEXT_LO, or PC > TEXT_HI. Comparisons are unsigned, 32-bit.
- AdEL handling:
  - F_ExcCode = 5'd4 when AdEL, else 0.
  - Instr_F = 0 (nop) when AdEL, so no bad word reaches D.
- eret handling: eret has no delay slot. When eret_D = 1, Instr_F = 0 and F_ExcCode = 0, which squashes the sequential fetch.
  - eret squash outranks AdEL: an AdEL on the squashed fetch is not reported.
- Otherwise Instr_F = i_inst_rdata.
- BDIn_F = is_jump_D, regardless of squash or AdEL.
- Next-PC priority, evaluated each rising edge (highest first):
  1. Req → HANDLER_PC. Overrides stall.
  2. enable_F = 0 → hold PC.
  3. eret_D → EPC.
  4. br_taken_D → br_target_D.
  5. Default → PC + 4, 32-bit wrap, carry discarded.
- No alignment or range masking of EPC or br_target_D. A bad target is flagged as AdEL one cycle later, when it becomes PC.
- A PC that fails AdEL still advances normally; the exception is taken via Req from CP0 downstream.

## Timing
- Reset:
  - reset = 0 forces PC = RESET_PC immediately (asynchronous), independent of clk.
  - Outputs follow combinationally: i_inst_addr = PC_F = 0x3000, F_ExcCode = 0. Instr_F = i_inst_rdata unless eret_D = 1. BDIn_F = is_jump_D.
- Deassertion of reset takes effect at the next rising edge. The first update leaves 0x3000.
- Latency:
  - Redirects (Req, eret, branch) update PC at the same edge on which the F/D register latches the current F values. The new PC is visible one cycle after the redirect input is asserted.
  - Combinational outputs are valid within the same cycle as the PC change.
- Simultaneous events:
  - Req with any other input → HANDLER_PC.
  - eret_D with br_taken_D → EPC.
  - enable_F = 0 with eret_D or br_taken_D → hold. The redirect is re-applied when the stall releases, because D holds its inputs during the stall.
- Reset mid-stall or mid-redirect → PC = RESET_PC. No pending state survives.

## Test plan
- Reset and sequential fetch:
  - Stimulus: reset low 3 cycles, then high, enable_F = 1, no redirects.
  - Required: PC_F = 0x3000, 0x3004, 0x3008 on successive edges. F_ExcCode = 0.
- Taken branch with delay slot:
  - Stimulus: at PC 0x3010 drive is_jump_D = 1, br_taken_D = 1, br_target_D = 0x3100 for one cycle.
  - Required: BDIn_F = 1 that cycle, Instr_F = i_inst_rdata. Next PC_F = 0x3100.
- Stall:
  - Stimulus: enable_F = 0 for 2 cycles at PC 0x3020 with br_taken_D = 1.
  - Required: PC_F held at 0x3020. On release, PC_F goes to br_target_D.
- Req overrides:
  - Stimulus: Req = 1 together with enable_F = 0 and eret_D = 1.
  - Required: next PC_F = 0x4180.
- eret squash:
  - Stimulus: eret_D = 1, EPC = 0x3204, PC = 0x4190.
  - Required: Instr_F = 0, F_ExcCode = 0. Next PC_F = 0x3204.
- AdEL:
  - Stimulus: br_target_D = 0x3002, then separately 0x7000.
  - Required: after the redirect, F_ExcCode = 4 and Instr_F = 0. PC then advances to 0x3006 and 0x7004 respectively.
